// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: HALT/STEP/RUN/TRAP clock-enable controller for the core.
// Define CPU_CLK_CTRL_DEBOUNCE_EN to debounce the step pushbutton.
module cpu_clk_ctrl #(
  parameter int DIV_W           = 32,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             step_btn_i,
  input  logic             halt_req_i,
  output logic             tick_o,
  output logic             led_o,
  output logic [1:0]       state_o,
  output logic [31:0]      tick_cnt_o
);

  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_STEP = 2'b01;
  localparam logic [1:0] S_RUN  = 2'b10;
  localparam logic [1:0] S_TRAP = 2'b11;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0]       mode_m, mode_s;
  logic             btn_m, btn_s, btn_d, btn_q;
  logic [1:0]       state, state_nx;
  logic [DIV_W-1:0] ctr, pm1;
  logic             run_q, run_tick, step_tick, tick_nx;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_m <= 2'b00;
      mode_s <= 2'b00;
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
      btn_q  <= 1'b0;
    end else begin
      mode_m <= mode_i;
      mode_s <= mode_m;
      btn_m  <= step_btn_i;
      btn_s  <= btn_m;
      btn_q  <= btn_d;
    end
  end

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam int DB_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt;

  // any return of btn_s to the accepted level restarts the count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt <= '0;
      btn_d  <= 1'b0;
    end else if (btn_s == btn_d) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      btn_d  <= btn_s;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) btn_d <= 1'b0;
    else         btn_d <= btn_s;
  end
`endif

  always_comb begin
    pm1 = div_i - DIV_W'(1);
    if (mode_s == 2'b11 || div_i == '0) pm1 = '0;
  end

  always_comb begin
    state_nx = state;
    if (state == S_TRAP) begin
      if (mode_s == 2'b00) state_nx = S_HALT;
    end else if (halt_req_i && state != S_HALT) begin
      state_nx = S_TRAP;
    end else begin
      unique case (1'b1)
        mode_s[1]:          state_nx = S_RUN;
        (mode_s == 2'b01):  state_nx = S_STEP;
        default:            state_nx = S_HALT;
      endcase
    end
  end

  // run_q delays the first count by one cycle after entering RUN
  assign run_tick  = (state == S_RUN) && run_q && (ctr >= pm1);
  assign step_tick = (state == S_STEP) && btn_d && !btn_q;
  assign tick_nx   = (run_tick || step_tick) && !halt_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_HALT;
      run_q <= 1'b0;
      ctr   <= '0;
    end else begin
      state <= state_nx;
      run_q <= (state == S_RUN);
      if (state != S_RUN || !run_q) ctr <= '0;
      else if (ctr >= pm1)          ctr <= '0;
      else                          ctr <= ctr + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_o     <= 1'b0;
      led_o      <= 1'b1;
      tick_cnt_o <= '0;
    end else begin
      tick_o <= tick_nx;
      if (tick_nx) begin
        led_o      <= ~led_o;
        tick_cnt_o <= tick_cnt_o + 32'd1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb_cpu_clk_ctrl: directed bench for cpu_clk_ctrl.
// Expected tick cycles are queued at stimulus time and matched later.
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  mode;
  logic [31:0] div;
  logic        btn;
  logic        halt;
  logic        tick;
  logic        led;
  logic [1:0]  state;
  logic [31:0] tick_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int exp_cnt = 0;
  int t, u, s, b, v, x, p, z;
  int exp_q[$];
  int got[$];

  cpu_clk_ctrl #(
    .DIV_W(32),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .mode_i(mode),
    .div_i(div),
    .step_btn_i(btn),
    .halt_req_i(halt),
    .tick_o(tick),
    .led_o(led),
    .state_o(state),
    .tick_cnt_o(tick_cnt)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (tick) got.push_back(cyc);

  initial begin
    #200_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, longint obs, longint expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tk(int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic expect_tick(int c);
    exp_q.push_back(c);
    exp_cnt++;
  endtask

  task automatic drain(string tag);
    int g, e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got.size() > 0) ? got.pop_front() : -1;
      chk({tag, "_tick_cycle"}, g, e);
    end
    chk({tag, "_extra_ticks"}, got.size(), 0);
    got.delete();
  endtask

  task automatic chk_cnt(string tag);
    chk({tag, "_cnt"}, tick_cnt, exp_cnt);
    chk({tag, "_led"}, led, 1 - (exp_cnt % 2));
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_led"}, led, 1);
    chk({tag, "_cnt"}, tick_cnt, 0);
  endtask

  initial begin
    mode = 2'b00;
    div  = 32'd4;
    btn  = 1'b0;
    halt = 1'b0;
    #5 rst_n = 1'b0;
    #1 chk_rst("reset");
    tk(2);
    rst_n = 1'b1;
    tk(2);
    chk("halt_idle", state, 0);

    // RUN, div 4
    t = cyc;
    mode = 2'b10;
    tk(2);
    chk("mode_lat_pre", state, 0);
    tk(1);
    chk("mode_lat", state, 2);
    expect_tick(t + 8);
    expect_tick(t + 12);
    expect_tick(t + 16);
    tk(5);
    chk("led_first", led, 0);
    tk(4);
    chk("led_second", led, 1);
    tk(4);
    chk("cnt_three", tick_cnt, 3);
    drain("run4");

    // mid-count reduction of div
    t = cyc;
    div = 32'd100;
    tk(50);
    chk("no_tick_mid", tick, 0);
    div = 32'd10;
    expect_tick(t + 51);
    expect_tick(t + 61);
    expect_tick(t + 71);
    tk(21);
    drain("div_cut");
    chk_cnt("div_cut");

    // div 0, then RUN-FAST with div ignored
    t = cyc;
    div = 32'd0;
    for (int i = 1; i <= 10; i++) expect_tick(t + i);
    tk(10);
    mode = 2'b11;
    div = 32'd7;
    for (int i = 13; i <= 22; i++) expect_tick(t + i);
    tk(12);
    drain("fast");
    chk_cnt("fast");

    // halt request on a due tick
    t = cyc;
    mode = 2'b10;
    div = 32'd2;
    expect_tick(t + 1);
    expect_tick(t + 2);
    expect_tick(t + 4);
    expect_tick(t + 6);
    tk(7);
    halt = 1'b1;
    tk(1);
    chk("halt_tick", tick, 0);
    chk("halt_trap", state, 3);
    halt = 1'b0;
    mode = 2'b01;
    tk(5);
    chk("trap_step", state, 3);
    mode = 2'b10;
    tk(5);
    chk("trap_run", state, 3);
    u = cyc;
    mode = 2'b00;
    tk(2);
    chk("trap_hold", state, 3);
    tk(1);
    chk("trap_exit", state, 0);
    mode = 2'b10;
    expect_tick(u + 9);
    expect_tick(u + 11);
    expect_tick(u + 13);
    tk(10);
    drain("trap");
    chk_cnt("trap");

    // STEP with a bouncing button
    s = cyc;
    mode = 2'b01;
    expect_tick(s + 2);
    tk(3);
    chk("step_state", state, 1);
    tk(2);
    b = cyc;
    btn = 1'b1;
    tk(3);
    btn = 1'b0;
    tk(3);
    btn = 1'b1;
    tk(20);
    btn = 1'b0;
`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
    expect_tick(b + 17);
`else
    expect_tick(b + 4);
    expect_tick(b + 10);
`endif
    tk(15);
    v = cyc;
    btn = 1'b1;
`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
    expect_tick(v + 11);
`else
    expect_tick(v + 4);
`endif
    tk(12);
    btn = 1'b0;
    drain("step");
    chk_cnt("step");

    // reset mid-count in RUN
    mode = 2'b10;
    div = 32'd100;
    tk(3);
    chk("run_again", state, 2);
    tk(30);
    rst_n = 1'b0;
    #1 chk_rst("rst_run");
    exp_cnt = 0;
    tk(2);
    rst_n = 1'b1;
    x = cyc;
    tk(1);
    chk("rel_tick", tick, 0);
    tk(1);
    chk("rel_state_pre", state, 0);
    tk(1);
    chk("rel_state", state, 2);
    tk(10);
    drain("rst_run");

    // reset mid-debounce in STEP
    mode = 2'b01;
    tk(4);
    chk("step_again", state, 1);
    p = cyc;
    btn = 1'b1;
    tk(2);
    rst_n = 1'b0;
    btn = 1'b0;
    #1 chk_rst("rst_step");
    tk(2);
    rst_n = 1'b1;
    z = cyc;
    tk(2);
    chk("rel2_state_pre", state, 0);
    tk(1);
    chk("rel2_state", state, 1);
    tk(12);
    drain("rst_step");
    chk_cnt("rst_step");

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
